// File: rtl/madv_dot_engine_if.sv
// ----------------------------------------------------------------------------
// madv_dot_engine_if
//   Bundles the load, exec and result handshake channels of madv_dot_engine,
//   together with its clear/abort input and its status outputs.
//   slave  : the engine side (inputs *_i, outputs *_o).
//   master : the CV-X-IF decode side that drives the engine.
//
//   load_*   : packed element words written into the A or B vector buffer.
//   exec_*   : starts a dot product. accumulate/a_signed/b_signed are
//              sampled together with exec.
//   result_* : dot product or accumulated value, held until consumed.
//   clear_i  : synchronous abort that also clears the engine's state.
//   overflow_o, busy_o : status outputs.
// ----------------------------------------------------------------------------
interface madv_dot_engine_if #(
  parameter int ELEM_W = 8,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32
);
  localparam int EPW   = DATA_W / ELEM_W;
  localparam int CNT_W = $clog2(EPW) + 1;

  logic              load_valid_i;
  logic              load_ready_o;
  logic              load_sel_i;
  logic [CNT_W-1:0]  load_count_i;
  logic [DATA_W-1:0] load_data_i;
  logic              exec_valid_i;
  logic              exec_ready_o;
  logic              accumulate_i;
  logic              a_signed_i;
  logic              b_signed_i;
  logic              clear_i;
  logic              result_valid_o;
  logic              result_ready_i;
  logic [ACC_W-1:0]  result_o;
  logic              overflow_o;
  logic              busy_o;

  modport slave (
    input  load_valid_i, load_sel_i, load_count_i, load_data_i,
           exec_valid_i, accumulate_i, a_signed_i, b_signed_i,
           clear_i, result_ready_i,
    output load_ready_o, exec_ready_o, result_valid_o, result_o,
           overflow_o, busy_o
  );

  modport master (
    output load_valid_i, load_sel_i, load_count_i, load_data_i,
           exec_valid_i, accumulate_i, a_signed_i, b_signed_i,
           clear_i, result_ready_i,
    input  load_ready_o, exec_ready_o, result_valid_o, result_o,
           overflow_o, busy_o
  );
endinterface

// File: rtl/madv_dot_engine.sv
// ----------------------------------------------------------------------------
// madv_dot_engine
//   Buffers an A and a B vector, each VEC_LEN elements long. It computes
//   their dot product through a registered radix-4 adder tree. The result
//   can optionally be added to a running accumulator.
//   Ports:
//     clk_i     : clock
//     rst_ni_i  : asynchronous active-low reset
//     bus       : madv_dot_engine_if.slave. It carries the load/exec/result
//                 handshakes, clear_i, overflow_o and busy_o.
//   Latency: result_valid_o rises LAT = ceil(log4(VEC_LEN)) + 2 cycles
//   after the exec handshake.
// ----------------------------------------------------------------------------
module madv_dot_engine #(
  parameter int VEC_LEN = 128,
  parameter int ELEM_W  = 8,
  parameter int DATA_W  = 32,
  parameter int ACC_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni_i,
  madv_dot_engine_if.slave   bus
);

  function automatic int clog4(input int n);
    int  s;
    longint p;
    s = 0;
    p = 1;
    while (p < longint'(n)) begin
      p = p * 4;
      s++;
    end
    return s;
  endfunction

  localparam int EPW    = DATA_W / ELEM_W;
  localparam int CNT_W  = $clog2(EPW) + 1;
  localparam int PTR_W  = $clog2(VEC_LEN + 1);
  localparam int PROD_W = 2 * ELEM_W + 2;
  localparam int NSTG   = clog4(VEC_LEN);
  localparam int NLEAF  = 4 ** NSTG;
  localparam int LAT    = NSTG + 2;
  localparam int LAT_W  = $clog2(LAT);

  // The tree nodes are stored level by level in one flat array:
  // first the leaves (products), then each radix-4 level, and the root last.
  function automatic int node_off(input int level);
    int o;
    o = 0;
    for (int i = 0; i < level; i++) o += NLEAF >> (2 * i);
    return o;
  endfunction

  localparam int NNODE = node_off(NSTG + 1);
  localparam int ROOT  = NNODE - 1;

  // Each element is extended by one bit: with its sign when its flag is set,
  // with zero otherwise. The product is then sign-extended to ACC_W.
  function automatic logic [ACC_W-1:0] mul_ext(input logic [ELEM_W-1:0] a,
                                               input logic [ELEM_W-1:0] b,
                                               input logic a_sgn,
                                               input logic b_sgn);
    logic signed [ELEM_W:0]   a_x;
    logic signed [ELEM_W:0]   b_x;
    logic signed [PROD_W-1:0] p;
    a_x = {a_sgn & a[ELEM_W-1], a};
    b_x = {b_sgn & b[ELEM_W-1], b};
    p   = PROD_W'(a_x) * PROD_W'(b_x);
    return ACC_W'(p);
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_RESP} state_e;

  state_e             state_q;
  logic [LAT_W-1:0]   lat_cnt_q;
  logic               accum_q, a_sgn_q, b_sgn_q;
  logic [ACC_W-1:0]   acc_q;
  logic               ovf_q;
  logic [PTR_W-1:0]   ptr_a_q, ptr_b_q;
  logic [ELEM_W-1:0]  buf_a_q [VEC_LEN];
  logic [ELEM_W-1:0]  buf_b_q [VEC_LEN];
  logic [ELEM_W-1:0]  buf_a_d [VEC_LEN];
  logic [ELEM_W-1:0]  buf_b_d [VEC_LEN];
  logic [ACC_W-1:0]   node_q  [NNODE];
  logic [ACC_W-1:0]   node_d  [NNODE];

  logic               idle, load_fire, exec_fire, wr_a, wr_b, load_drop;
  logic [CNT_W-1:0]   eff_cnt;
  logic [PTR_W:0]     ptr_sum;
  logic [PTR_W-1:0]   ptr_next;

  assign idle      = (state_q == S_IDLE);
  assign load_fire = idle & bus.load_valid_i;
  // A load has priority over an exec when both are valid in the same cycle.
  assign exec_fire = idle & bus.exec_valid_i & ~bus.load_valid_i;
  assign wr_a      = load_fire & ~bus.load_sel_i;
  assign wr_b      = load_fire &  bus.load_sel_i;

  assign eff_cnt   = (bus.load_count_i > CNT_W'(EPW)) ? CNT_W'(EPW) : bus.load_count_i;
  assign ptr_sum   = {1'b0, (bus.load_sel_i ? ptr_b_q : ptr_a_q)} + (PTR_W+1)'(eff_cnt);
  // If ptr + count runs past VEC_LEN, at least one element of the word is
  // dropped.
  assign load_drop = (ptr_sum > (PTR_W+1)'(VEC_LEN));
  assign ptr_next  = load_drop ? PTR_W'(VEC_LEN) : ptr_sum[PTR_W-1:0];

  // Next-state buffers. Entry e takes lane (e - ptr) of the load word when
  // that lane falls inside the effective count; otherwise it keeps its value.
  for (genvar e = 0; e < VEC_LEN; e++) begin : g_buf
    localparam logic [PTR_W:0] E = (PTR_W+1)'(e);
    logic [PTR_W:0] lane_a, lane_b;
    logic           hit_a, hit_b;
    assign lane_a = E - {1'b0, ptr_a_q};
    assign lane_b = E - {1'b0, ptr_b_q};
    assign hit_a  = wr_a & (E >= {1'b0, ptr_a_q}) & (lane_a < (PTR_W+1)'(eff_cnt));
    assign hit_b  = wr_b & (E >= {1'b0, ptr_b_q}) & (lane_b < (PTR_W+1)'(eff_cnt));
    assign buf_a_d[e] = hit_a ? ELEM_W'(bus.load_data_i >> (int'(lane_a) * ELEM_W)) : buf_a_q[e];
    assign buf_b_d[e] = hit_b ? ELEM_W'(bus.load_data_i >> (int'(lane_b) * ELEM_W)) : buf_b_q[e];
  end

  // Leaves past VEC_LEN pad the tree out to a full power of four. They are
  // tied to zero.
  for (genvar j = 0; j < NLEAF; j++) begin : g_leaf
    if (j < VEC_LEN) begin : g_used
      assign node_d[j] = mul_ext(buf_a_q[j], buf_b_q[j], a_sgn_q, b_sgn_q);
    end else begin : g_pad
      assign node_d[j] = '0;
    end
  end

  for (genvar k = 1; k <= NSTG; k++) begin : g_lvl
    for (genvar j = 0; j < (NLEAF >> (2 * k)); j++) begin : g_node
      localparam int D = node_off(k) + j;
      localparam int S = node_off(k - 1) + 4 * j;
      assign node_d[D] = node_q[S] + node_q[S+1] + node_q[S+2] + node_q[S+3];
    end
  end

  // The pipeline runs freely from the buffers. Loads are only accepted in
  // IDLE, so the buffers hold steady for the whole of a COMPUTE phase.
  // NOTE: this tree and the buffers are reset like any other flop, because
  // the spec requires them to read 0 after reset. Otherwise a flop array
  // would normally be left unreset.
  always_ff @(posedge clk_i or negedge rst_ni_i) begin
    if (!rst_ni_i)        node_q <= '{default: '0};
    else if (bus.clear_i) node_q <= '{default: '0};
    else                  node_q <= node_d;
  end

  // NOTE: every register below uses a non-blocking assignment, so each branch
  // reads the values from before the edge. For example, acc_q + node_q[ROOT]
  // uses the old acc_q.
  always_ff @(posedge clk_i or negedge rst_ni_i) begin
    if (!rst_ni_i) begin
      state_q   <= S_IDLE;
      lat_cnt_q <= '0;
      accum_q   <= 1'b0;
      a_sgn_q   <= 1'b0;
      b_sgn_q   <= 1'b0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      ptr_a_q   <= '0;
      ptr_b_q   <= '0;
      buf_a_q   <= '{default: '0};
      buf_b_q   <= '{default: '0};
    end else if (bus.clear_i) begin
      state_q   <= S_IDLE;
      lat_cnt_q <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      ptr_a_q   <= '0;
      ptr_b_q   <= '0;
      buf_a_q   <= '{default: '0};
      buf_b_q   <= '{default: '0};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_fire) begin
            buf_a_q <= buf_a_d;
            buf_b_q <= buf_b_d;
            if (bus.load_sel_i) ptr_b_q <= ptr_next;
            else                ptr_a_q <= ptr_next;
            if (load_drop) ovf_q <= 1'b1;
          end else if (exec_fire) begin
            state_q   <= S_COMPUTE;
            lat_cnt_q <= '0;
            accum_q   <= bus.accumulate_i;
            a_sgn_q   <= bus.a_signed_i;
            b_sgn_q   <= bus.b_signed_i;
          end
        end
        S_COMPUTE: begin
          lat_cnt_q <= lat_cnt_q + LAT_W'(1);
          if (lat_cnt_q == LAT_W'(LAT - 1)) begin
            state_q <= S_RESP;
            acc_q   <= accum_q ? (acc_q + node_q[ROOT]) : node_q[ROOT];
          end
        end
        S_RESP: begin
          // After a completed response, both buffers start again from empty.
          // The accumulator and the overflow flag are kept.
          if (bus.result_ready_i) begin
            state_q <= S_IDLE;
            ptr_a_q <= '0;
            ptr_b_q <= '0;
            buf_a_q <= '{default: '0};
            buf_b_q <= '{default: '0};
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.load_ready_o   = idle;
  assign bus.exec_ready_o   = idle & ~bus.load_valid_i;
  assign bus.result_valid_o = (state_q == S_RESP);
  assign bus.result_o       = acc_q;
  assign bus.overflow_o     = ovf_q;
  assign bus.busy_o         = ~idle;

endmodule
